// File: rtl/mem_responder_if.sv
// Request/response bus between the core's memory port and mem_responder.
// The requester drives req_* and the responder drives req_ready and resp_*.
interface mem_responder_if;
    logic        req_valid;
    logic        req_write;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        req_ready;
    logic        resp_valid;
    logic [31:0] resp_rdata;
    logic        resp_err;

    modport master (
        output req_valid, req_write, req_addr, req_wdata,
        input  req_ready, resp_valid, resp_rdata, resp_err
    );

    modport slave (
        input  req_valid, req_write, req_addr, req_wdata,
        output req_ready, resp_valid, resp_rdata, resp_err
    );
endinterface

// File: rtl/mem_responder.sv
// Memory-side responder for the multicycle MIPS memory port.
// A word-addressed RAM sits behind a valid/ready request and a single-cycle
// response pulse, with WAIT_STATES extra cycles between accept and response.
// Misaligned or out-of-range accesses respond with resp_err and read data 0,
// and never touch the RAM.
module mem_responder #(
    parameter int unsigned DEPTH_WORDS = 256,
    parameter int unsigned WAIT_STATES = 1
) (
    input  logic           i_clk,
    input  logic           i_reset,
    mem_responder_if.slave io_bus
);
    localparam int unsigned AW = $clog2(DEPTH_WORDS);

    typedef enum logic [1:0] {
        S_IDLE,
        S_WAIT,
        S_RESP
    } state_t;

    state_t        r_state;
    state_t        w_next;
    logic [3:0]    r_cnt;
    logic          r_write;
    logic [31:0]   r_addr;
    logic [31:0]   r_wdata;
    logic [31:0]   r_rdata;
    logic [31:0]   r_mem [DEPTH_WORDS];

    logic          w_accept;
    logic          w_enter_resp;
    logic          w_src_write;
    logic [31:0]   w_src_addr;
    logic          w_src_err;
    logic [AW-1:0] w_src_idx;
    logic          w_cur_err;
    logic [AW-1:0] w_cur_idx;
    logic          w_commit;

    // Misaligned, or word index beyond the end of the RAM.
    function automatic logic addr_err(input logic [31:0] a);
        return (a[1:0] != 2'b00) || (a[31:2] >= 30'(DEPTH_WORDS));
    endfunction

    // With no wait states the edge that accepts the request is also the edge
    // entering RESP, so the read must use the live request (which is exactly
    // what gets latched on that edge) rather than the not-yet-updated latch.
    assign w_src_addr  = (r_state == S_IDLE) ? io_bus.req_addr  : r_addr;
    assign w_src_write = (r_state == S_IDLE) ? io_bus.req_write : r_write;
    assign w_src_err   = addr_err(w_src_addr);
    assign w_src_idx   = w_src_addr[AW+1:2];

    assign w_cur_err   = addr_err(r_addr);
    assign w_cur_idx   = r_addr[AW+1:2];

    assign w_enter_resp = (w_next == S_RESP) && (r_state != S_RESP);

    // A store commits on the edge leaving RESP, unless reset aborts it.
    assign w_commit = i_reset && (r_state == S_RESP) && r_write && !w_cur_err;

    assign io_bus.resp_rdata = r_rdata;

    // Next-state decode and handshake outputs.
    always_comb begin
        w_next            = r_state;
        w_accept          = 1'b0;
        io_bus.req_ready  = 1'b0;
        io_bus.resp_valid = 1'b0;
        io_bus.resp_err   = 1'b0;
        case (r_state)
            S_IDLE: begin
                io_bus.req_ready = 1'b1;
                if (io_bus.req_valid) begin
                    w_accept = 1'b1;
                    w_next   = (WAIT_STATES == 0) ? S_RESP : S_WAIT;
                end
            end
            S_WAIT: begin
                if (r_cnt <= 4'd1) begin
                    w_next = S_RESP;
                end
            end
            S_RESP: begin
                io_bus.resp_valid = 1'b1;
                io_bus.resp_err   = w_cur_err;
                w_next            = S_IDLE;
            end
            default: begin
                w_next = S_IDLE;
            end
        endcase
    end

    // State, request latch, wait counter and registered read data.
    always_ff @(posedge i_clk) begin
        if (!i_reset) begin
            r_state <= S_IDLE;
            r_cnt   <= '0;
            r_write <= 1'b0;
            r_addr  <= '0;
            r_wdata <= '0;
            r_rdata <= '0;
        end else begin
            r_state <= w_next;
            if (w_accept) begin
                r_cnt   <= 4'(WAIT_STATES);
                r_write <= io_bus.req_write;
                r_addr  <= io_bus.req_addr;
                r_wdata <= io_bus.req_wdata;
            end else if ((r_state == S_WAIT) && (r_cnt != 4'd0)) begin
                r_cnt <= r_cnt - 4'd1;
            end
            if (w_enter_resp) begin
                if (w_src_err) begin
                    r_rdata <= '0;
                end else if (!w_src_write) begin
                    r_rdata <= r_mem[w_src_idx];
                end
            end
        end
    end

    // RAM write port; contents survive reset.
    always_ff @(posedge i_clk) begin
        if (w_commit) begin
            r_mem[w_cur_idx] <= r_wdata;
        end
    end
endmodule
